// File: rtl/i2c_ball_intf.sv
// i2c_ball_intf: single-master, write-only I2C transmitter that sends a ball-state frame on request.
// Define I2C_CHECKSUM_EN to append an XOR checksum byte after ball_vy.
module i2c_ball_intf #(
  parameter int unsigned CLK_FREQ   = 100_000_000,
  parameter int unsigned I2C_FREQ   = 100_000,
  parameter logic [6:0]  SLAVE_ADDR = 7'h42
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ball_send_trigger,
  input  logic [9:0]  ball_y,
  input  logic [7:0]  ball_vy,
  output logic        SCL,
  inout  wire         SDA,
  output logic        is_transfer,
  output logic [15:0] led
);

  localparam int unsigned QUARTER = CLK_FREQ / (4 * I2C_FREQ);
  localparam int unsigned QW      = (QUARTER > 1) ? $clog2(QUARTER) : 1;
`ifdef I2C_CHECKSUM_EN
  localparam int unsigned NUM_BYTES = 5;
`else
  localparam int unsigned NUM_BYTES = 4;
`endif
  localparam logic [2:0]    LAST_BYTE = 3'(NUM_BYTES - 1);
  localparam logic [QW-1:0] Q_LAST    = QW'(QUARTER - 1);

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    START      = 3'd1,
    WRITE_ACK  = 3'd2,
    WRITE_DATA = 3'd3,
    STOP       = 3'd4
  } state_t;

  state_t        state, state_n;
  logic [QW-1:0] q_cnt, q_cnt_n;
  logic [1:0]    qtr, qtr_n;
  logic [2:0]    bit_cnt, bit_cnt_n;
  logic [2:0]    byte_idx, byte_idx_n;
  logic [7:0]    tx_byte, tx_byte_n;
  logic [7:0]    next_byte;
  logic [1:0]    y_hi, y_hi_n;
  logic [7:0]    y_lo, y_lo_n;
  logic [7:0]    vy, vy_n;
  logic          ack, ack_n;
  logic          scl_n;
  logic          sda_low, sda_low_n;
  logic          is_transfer_n;
  logic          tick;

  // Open-drain data line: only ever pulled low or released
  assign SDA  = sda_low ? 1'b0 : 1'bz;
  assign tick = (q_cnt == Q_LAST);

  // Byte that follows the one at byte_idx
  always_comb begin
    next_byte = 8'h00;
    case (byte_idx)
      3'd0:    next_byte = {6'b0, y_hi};
      3'd1:    next_byte = y_lo;
      3'd2:    next_byte = vy;
      default: next_byte = {6'b0, y_hi} ^ y_lo ^ vy;
    endcase
  end

  always_comb begin
    state_n       = state;
    q_cnt_n       = q_cnt;
    qtr_n         = qtr;
    bit_cnt_n     = bit_cnt;
    byte_idx_n    = byte_idx;
    tx_byte_n     = tx_byte;
    y_hi_n        = y_hi;
    y_lo_n        = y_lo;
    vy_n          = vy;
    ack_n         = ack;
    is_transfer_n = is_transfer;
    scl_n         = 1'b1;
    sda_low_n     = 1'b0;

    if (state == IDLE) begin
      if (ball_send_trigger) begin
        y_hi_n        = ball_y[9:8];
        y_lo_n        = ball_y[7:0];
        vy_n          = ball_vy;
        state_n       = START;
        is_transfer_n = 1'b1;
        q_cnt_n       = '0;
        qtr_n         = 2'd0;
        byte_idx_n    = 3'd0;
        bit_cnt_n     = 3'd0;
      end
    end else begin
      q_cnt_n = tick ? '0 : q_cnt + QW'(1);
      if (tick) qtr_n = qtr + 2'd1;
      // ACK is sampled on the last clock of q2, mid SCL-high
      if (state == WRITE_ACK && tick && qtr == 2'd2) begin
        if (SDA == 1'b0) ack_n = 1'b1;
        else             ack_n = 1'b0;
      end
      if (tick && qtr == 2'd3) begin
        case (state)
          START: begin
            state_n   = WRITE_DATA;
            tx_byte_n = {SLAVE_ADDR, 1'b0};
            bit_cnt_n = 3'd0;
          end
          WRITE_DATA: begin
            if (bit_cnt == 3'd7) begin
              state_n = WRITE_ACK;
            end else begin
              bit_cnt_n = bit_cnt + 3'd1;
              tx_byte_n = {tx_byte[6:0], 1'b0};
            end
          end
          WRITE_ACK: begin
            if (ack && byte_idx != LAST_BYTE) begin
              state_n    = WRITE_DATA;
              byte_idx_n = byte_idx + 3'd1;
              tx_byte_n  = next_byte;
              bit_cnt_n  = 3'd0;
            end else begin
              state_n = STOP;
            end
          end
          STOP: begin
            state_n       = IDLE;
            is_transfer_n = 1'b0;
          end
          default: state_n = IDLE;
        endcase
      end
    end

    // Pin levels for the upcoming state/quarter so SCL/SDA are registered
    case (state_n)
      START: begin
        scl_n     = (qtr_n < 2'd2);
        sda_low_n = (qtr_n != 2'd0);
      end
      WRITE_DATA: begin
        scl_n     = qtr_n[1];
        sda_low_n = ~tx_byte_n[7];
      end
      WRITE_ACK: begin
        scl_n     = qtr_n[1];
        sda_low_n = 1'b0;
      end
      STOP: begin
        scl_n     = (qtr_n != 2'd0);
        sda_low_n = (qtr_n < 2'd2);
      end
      default: begin
        scl_n     = 1'b1;
        sda_low_n = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      q_cnt       <= '0;
      qtr         <= 2'd0;
      bit_cnt     <= 3'd0;
      byte_idx    <= 3'd0;
      tx_byte     <= 8'h00;
      y_hi        <= 2'd0;
      y_lo        <= 8'h00;
      vy          <= 8'h00;
      ack         <= 1'b0;
      SCL         <= 1'b1;
      sda_low     <= 1'b0;
      is_transfer <= 1'b0;
      led         <= 16'h0000;
    end else begin
      state       <= state_n;
      q_cnt       <= q_cnt_n;
      qtr         <= qtr_n;
      bit_cnt     <= bit_cnt_n;
      byte_idx    <= byte_idx_n;
      tx_byte     <= tx_byte_n;
      y_hi        <= y_hi_n;
      y_lo        <= y_lo_n;
      vy          <= vy_n;
      ack         <= ack_n;
      SCL         <= scl_n;
      sda_low     <= sda_low_n;
      is_transfer <= is_transfer_n;
      led         <= {4'(state_n), 11'b0, is_transfer_n};
    end
  end

endmodule

// File: tb/tb_i2c_ball_intf.sv
// tb_i2c_ball_intf: directed bench for i2c_ball_intf with a bus monitor and an ACKing slave.
// Runs at a 4 MHz clock with 100 kHz SCL: quarter = 10 clocks, bit = 40 clocks = 10 us.
module tb_i2c_ball_intf;

  localparam int BIT_CLKS = 40;
`ifdef I2C_CHECKSUM_EN
  localparam int NB = 5;
`else
  localparam int NB = 4;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        ball_send_trigger = 1'b0;
  logic [9:0]  ball_y = '0;
  logic [7:0]  ball_vy = '0;
  logic        SCL;
  wire         SDA;
  logic        is_transfer;
  logic [15:0] led;

  logic ack_en = 1'b1;
  logic slave_pull = 1'b0;

  int checks = 0;
  int errors = 0;

  logic bits[$];
  int starts = 0, stops = 0, scl_edges = 0;
  int cyc = 0, last_rise = 0, scl_per = 0;
  int s0, p0, e0;

  i2c_ball_intf #(
    .CLK_FREQ  (4_000_000),
    .I2C_FREQ  (100_000),
    .SLAVE_ADDR(7'h42)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .ball_send_trigger(ball_send_trigger),
    .ball_y           (ball_y),
    .ball_vy          (ball_vy),
    .SCL              (SCL),
    .SDA              (SDA),
    .is_transfer      (is_transfer),
    .led              (led)
  );

  pullup (SDA);
  assign SDA = slave_pull ? 1'b0 : 1'bz;

  always #5 clk = ~clk;

  // Slave holds SDA low for the whole ACK bit when acknowledging
  always @(negedge clk) slave_pull = ack_en && (led == 16'h2001);

  always @(posedge clk) cyc++;
  always @(SCL) scl_edges++;
  always @(negedge SDA) if (SCL === 1'b1) begin starts++; bits.delete(); end
  always @(posedge SDA) if (SCL === 1'b1) stops++;
  always @(posedge SCL) begin
    bits.push_back(SDA);
    scl_per   = cyc - last_rise;
    last_rise = cyc;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] rx_byte(input int idx);
    logic [7:0] b = 8'h00;
    for (int k = 0; k < 8; k++)
      if (9 * idx + k < bits.size()) b[7 - k] = bits[9 * idx + k];
    return b;
  endfunction

  function automatic logic rx_ack(input int idx);
    if (9 * idx + 8 < bits.size()) return bits[9 * idx + 8];
    return 1'bx;
  endfunction

  task automatic send(input logic [9:0] y, input logic [7:0] v);
    @(negedge clk);
    ball_y = y;
    ball_vy = v;
    ball_send_trigger = 1'b1;
    @(negedge clk);
    ball_send_trigger = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (is_transfer && n < 4000) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_done"}, {31'b0, is_transfer}, 32'd0);
  endtask

  task automatic check_frame(input string tag, input logic [7:0] b1, b2, b3);
    logic [7:0] exp [5];
    exp[0] = 8'h84;
    exp[1] = b1;
    exp[2] = b2;
    exp[3] = b3;
    exp[4] = b1 ^ b2 ^ b3;
    chk({tag, "_nbits"}, 32'(bits.size()), 32'(9 * NB + 1));
    for (int i = 0; i < NB; i++) begin
      chk($sformatf("%s_byte%0d", tag, i), {24'b0, rx_byte(i)}, {24'b0, exp[i]});
      chk($sformatf("%s_ack%0d", tag, i), {31'b0, rx_ack(i)}, 32'd0);
    end
  endtask

  initial begin
    // Reset and idle
    repeat (3) @(negedge clk);
    chk("rst_scl", {31'b0, SCL}, 32'd1);
    chk("rst_sda", {31'b0, SDA}, 32'd1);
    chk("rst_busy", {31'b0, is_transfer}, 32'd0);
    chk("rst_led", {16'b0, led}, 32'h0000);
    reset = 1'b1;
    e0 = scl_edges;
    repeat (100) @(negedge clk);
    chk("idle_scl_edges", 32'(scl_edges - e0), 32'd0);
    chk("idle_led", {16'b0, led}, 32'h0000);

    // Basic frame: y=300 (0x12C), vy=20 (0x14)
    s0 = starts;
    p0 = stops;
    send(10'd300, 8'd20);
    chk("basic_busy", {31'b0, is_transfer}, 32'd1);
    chk("basic_led_start", {16'b0, led}, 32'h1001);
    repeat (400) @(negedge clk);
    chk("basic_scl_period", 32'(scl_per), 32'(BIT_CLKS));
    wait_idle("basic");
    chk("basic_starts", 32'(starts - s0), 32'd1);
    chk("basic_stops", 32'(stops - p0), 32'd1);
    check_frame("basic", 8'h01, 8'h2C, 8'h14);
    chk("basic_led_end", {16'b0, led}, 32'h0000);

    // NACK on address byte
    ack_en = 1'b0;
    p0 = stops;
    send(10'd300, 8'd20);
    wait_idle("nack");
    ack_en = 1'b1;
    chk("nack_nbits", 32'(bits.size()), 32'd10);
    chk("nack_addr", {24'b0, rx_byte(0)}, 32'h84);
    chk("nack_ackbit", {31'b0, rx_ack(0)}, 32'd1);
    chk("nack_stops", 32'(stops - p0), 32'd1);

    // Trigger while busy is ignored
    s0 = starts;
    send(10'd300, 8'd20);
    repeat (300) @(negedge clk);
    send(10'd513, 8'd7);
    wait_idle("busy");
    check_frame("busy", 8'h01, 8'h2C, 8'h14);
    repeat (200) @(negedge clk);
    chk("busy_no_second", {31'b0, is_transfer}, 32'd0);
    chk("busy_starts", 32'(starts - s0), 32'd1);

    // Inputs change right after the trigger
    send(10'd1023, 8'hAA);
    ball_y = 10'd5;
    ball_vy = 8'd5;
    wait_idle("latch");
    check_frame("latch", 8'h03, 8'hFF, 8'hAA);

    // Reset during the address byte
    send(10'd300, 8'd20);
    repeat (100) @(negedge clk);
    reset = 1'b0;
    #1;
    chk("midrst_scl", {31'b0, SCL}, 32'd1);
    chk("midrst_sda", {31'b0, SDA}, 32'd1);
    chk("midrst_busy", {31'b0, is_transfer}, 32'd0);
    chk("midrst_led", {16'b0, led}, 32'h0000);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    send(10'd300, 8'd20);
    wait_idle("after_rst");
    check_frame("after_rst", 8'h01, 8'h2C, 8'h14);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
